// File: rtl/sha_nonce_scheduler_if.sv
// Scheduler-side bundle: job control, per-core start/nonce/done/hash lanes and the shared memory write port.
interface sha_nonce_scheduler_if #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 16
);
  logic                       start;
  logic [ADDR_W-1:0]          output_addr;
  logic                       done;
  logic [NUM_CORES-1:0]       core_start;
  logic [NUM_CORES-1:0][31:0] core_nonce;
  logic [NUM_CORES-1:0]       core_done;
  logic [NUM_CORES-1:0][31:0] core_hash;
  logic                       mem_we;
  logic [ADDR_W-1:0]          mem_addr;
  logic [31:0]                mem_write_data;

  modport slave (
    input  start, output_addr, core_done, core_hash,
    output done, core_start, core_nonce, mem_we, mem_addr, mem_write_data
  );

  modport master (
    output start, output_addr, core_done, core_hash,
    input  done, core_start, core_nonce, mem_we, mem_addr, mem_write_data
  );
endinterface

// File: rtl/sha_nonce_scheduler.sv
// Nonce job scheduler for NUM_CORES SHA-256 cores; serialises H0 results onto one memory write port.
// Optional feature macro SCHED_STATS_EN adds the stat_cycles RUN-cycle counter output.

// Per-core slot: busy/pending tracking, issued nonce and captured hash for one core.
module sha_nonce_slot (
  input  logic        clk,
  input  logic        reset,
  input  logic        disp_i,
  input  logic [15:0] nonce_i,
  input  logic        done_i,
  input  logic [31:0] hash_i,
  input  logic        grant_i,
  output logic        busy_o,
  output logic        pend_o,
  output logic        start_o,
  output logic [31:0] nonce_o,
  output logic [31:0] hash_o
);
  logic        busy_q, pend_q, start_q, cap;
  logic [31:0] nonce_q, hash_q;

  // A completion is visible to the arbiter in the same cycle it arrives.
  assign cap     = done_i & busy_q & ~pend_q;
  assign pend_o  = pend_q | cap;
  assign hash_o  = cap ? hash_i : hash_q;
  assign busy_o  = busy_q;
  assign start_o = start_q;
  assign nonce_o = nonce_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q  <= 1'b0;
      pend_q  <= 1'b0;
      start_q <= 1'b0;
      nonce_q <= '0;
      hash_q  <= '0;
    end else begin
      start_q <= disp_i;
      pend_q  <= pend_o & ~grant_i;
      if (cap) hash_q <= hash_i;
      if (disp_i) begin
        busy_q  <= 1'b1;
        nonce_q <= {16'h0, nonce_i};
      end else if (grant_i) begin
        busy_q <= 1'b0;
      end
    end
  end
endmodule

module sha_nonce_scheduler #(
  parameter int NUM_CORES  = 4,
  parameter int NUM_NONCES = 16,
  parameter int ADDR_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  sha_nonce_scheduler_if.slave  bus
`ifdef SCHED_STATS_EN
  ,
  output logic [31:0]           stat_cycles
`endif
);
  localparam int          PW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [15:0] NN = 16'(NUM_NONCES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e                     state_q;
  logic                       done_q, mem_we_q;
  logic [ADDR_W-1:0]          base_q, mem_addr_q;
  logic [31:0]                mem_data_q;
  logic [15:0]                next_nonce_q, written_cnt_q;
  logic [PW-1:0]              rr_ptr_q;

  logic [NUM_CORES-1:0]       busy, pend, disp, grant, start_v;
  logic [NUM_CORES-1:0][31:0] nonce_v, hash_v;
  logic                       grant_any, found;
  logic [PW-1:0]              grant_idx;
  int                         idx;

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_slot
    sha_nonce_slot u_slot (
      .clk     (clk),
      .reset   (reset),
      .disp_i  (disp[i]),
      .nonce_i (next_nonce_q),
      .done_i  (bus.core_done[i]),
      .hash_i  (bus.core_hash[i]),
      .grant_i (grant[i]),
      .busy_o  (busy[i]),
      .pend_o  (pend[i]),
      .start_o (start_v[i]),
      .nonce_o (nonce_v[i]),
      .hash_o  (hash_v[i])
    );
  end

  // Lowest-index idle core takes the next nonce; busy is registered so a
  // core freed by this cycle's write is only seen idle next cycle.
  always_comb begin
    disp  = '0;
    found = 1'b0;
    if (state_q == RUN && next_nonce_q < NN) begin
      for (int i = 0; i < NUM_CORES; i++) begin
        if (!found && !busy[i]) begin
          disp[i] = 1'b1;
          found   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_CORES;
      if (!grant_any && pend[idx]) begin
        grant_any = 1'b1;
        grant_idx = PW'(idx);
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      done_q        <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_q    <= '0;
      base_q        <= '0;
      next_nonce_q  <= '0;
      written_cnt_q <= '0;
      rr_ptr_q      <= '0;
    end else begin
      mem_we_q <= grant_any;
      if (grant_any) begin
        mem_addr_q    <= base_q + ADDR_W'(nonce_v[grant_idx]);
        mem_data_q    <= hash_v[grant_idx];
        written_cnt_q <= written_cnt_q + 16'd1;
        rr_ptr_q      <= (grant_idx == PW'(NUM_CORES - 1)) ? '0 : grant_idx + PW'(1);
      end
      if (|disp) next_nonce_q <= next_nonce_q + 16'd1;
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            state_q       <= RUN;
            done_q        <= 1'b0;
            base_q        <= bus.output_addr;
            next_nonce_q  <= '0;
            written_cnt_q <= '0;
          end
        end
        RUN: begin
          if (written_cnt_q == NN) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.done           = done_q;
  assign bus.core_start     = start_v;
  assign bus.core_nonce     = nonce_v;
  assign bus.mem_we         = mem_we_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_write_data = mem_data_q;

`ifdef SCHED_STATS_EN
  logic [31:0] stat_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stat_q <= '0;
    end else if (state_q != RUN && bus.start) begin
      stat_q <= '0;
    end else if (state_q == RUN && stat_q != 32'hFFFF_FFFF) begin
      stat_q <= stat_q + 32'd1;
    end
  end

  assign stat_cycles = stat_q;
`endif
endmodule

// File: tb/tb_sha_nonce_scheduler.sv
// Randomised bench for sha_nonce_scheduler: behavioural core array plus an address/data scoreboard.
module tb_sha_nonce_scheduler;
  localparam int NC = 4;
  localparam int NN = 16;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sha_nonce_scheduler_if #(.NUM_CORES(NC), .ADDR_W(AW)) bus ();
`ifdef SCHED_STATS_EN
  logic [31:0] stat_cycles;
`endif

  sha_nonce_scheduler #(.NUM_CORES(NC), .NUM_NONCES(NN), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef SCHED_STATS_EN
    ,
    .stat_cycles (stat_cycles)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // behavioural cores and job reference
  int              mc_cnt[NC];
  logic [31:0]     mc_nonce[NC];
  bit              mc_rdy[NC];
  bit              hold, sync_mode, fixed_lat, first_seen;
  logic [31:0]     key;
  logic [AW-1:0]   base;
  bit              seen[NN];
  int              wr_cnt, cyc_no, last_wr_cyc, burst_rem, bursts, run_cnt;
  logic [AW-1:0]   burst_q[$];

  function automatic bit all_rdy();
    bit r = 1'b1;
    for (int i = 0; i < NC; i++) r &= mc_rdy[i];
    return r;
  endfunction

  task automatic pulse(input int i);
    bus.core_done[i] = 1'b1;
    bus.core_hash[i] = mc_nonce[i] ^ key;
    mc_rdy[i]        = 1'b0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NC; i++) begin
      mc_cnt[i] = 0;
      mc_rdy[i] = 1'b0;
    end
    bus.core_done = '0;
    burst_q.delete();
    burst_rem = 0;
  endtask

  task automatic cyc();
    int off;
    @(posedge clk);
    #1;
    cyc_no++;
    if (bus.mem_we) begin
      off = int'(AW'(bus.mem_addr - base));
      chk("wr_in_range", 64'(off < NN), 1);
      if (off < NN) begin
        chk("wr_data", bus.mem_write_data, 32'(off) ^ key);
        chk("wr_once", 64'(seen[off]), 0);
        seen[off] = 1'b1;
      end
      wr_cnt++;
      last_wr_cyc = cyc_no;
    end
    if (burst_rem > 0) begin
      chk("burst_we", bus.mem_we, 1);
      if (burst_q.size() > 0) chk("burst_order", bus.mem_addr, burst_q.pop_front());
      burst_rem--;
    end
    bus.core_done = '0;
    for (int i = 0; i < NC; i++) begin
      if (bus.core_start[i]) begin
        if (!first_seen) begin
          first_seen = 1'b1;
          chk("first_nonce", bus.core_nonce[i], 0);
        end
        mc_nonce[i] = bus.core_nonce[i];
        mc_cnt[i]   = fixed_lat ? 10 : int'($urandom_range(1, 15));
        mc_rdy[i]   = 1'b0;
      end else if (mc_cnt[i] > 0) begin
        chk("nonce_stable", bus.core_nonce[i], mc_nonce[i]);
        mc_cnt[i]--;
        if (mc_cnt[i] == 0) mc_rdy[i] = 1'b1;
      end
    end
    if (sync_mode) begin
      if (all_rdy()) begin
        for (int i = 0; i < NC; i++) begin
          burst_q.push_back(AW'(base + AW'(mc_nonce[i])));
          pulse(i);
        end
        burst_rem = NC;
        bursts++;
      end
    end else if (!hold) begin
      for (int i = 0; i < NC; i++) if (mc_rdy[i]) pulse(i);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_done"},  bus.done, 0);
    chk({tag, "_cstart"}, bus.core_start, 0);
    chk({tag, "_cnonce"}, 64'(|bus.core_nonce), 0);
    chk({tag, "_we"},    bus.mem_we, 0);
    chk({tag, "_addr"},  bus.mem_addr, 0);
    chk({tag, "_wdata"}, bus.mem_write_data, 0);
`ifdef SCHED_STATS_EN
    chk({tag, "_stat"},  stat_cycles, 0);
`endif
  endtask

  task automatic new_job(input logic [AW-1:0] b, input logic [31:0] k);
    base = b;
    key  = k;
    for (int i = 0; i < NN; i++) seen[i] = 1'b0;
    wr_cnt     = 0;
    first_seen = 1'b0;
    bus.output_addr = b;
    bus.start       = 1'b1;
    cyc();
    bus.start       = 1'b0;
    bus.output_addr = AW'($urandom);
    chk("start_done_low", bus.done, 0);
    run_cnt = 1;
`ifdef SCHED_STATS_EN
    chk("stat_cleared", stat_cycles, 0);
`endif
  endtask

  task automatic finish_job(input string tag);
    int t = 0;
    int miss = 0;
    while (!bus.done && t < 3000) begin
      cyc();
      t++;
      if (!bus.done) run_cnt++;
    end
    chk({tag, "_done"}, bus.done, 1);
    chk({tag, "_wr_cnt"}, wr_cnt, NN);
    chk({tag, "_done_lat"}, cyc_no - last_wr_cyc, 1);
    for (int i = 0; i < NN; i++) if (!seen[i]) miss++;
    chk({tag, "_missing"}, miss, 0);
`ifdef SCHED_STATS_EN
    chk({tag, "_stat"}, stat_cycles, run_cnt);
    repeat (3) cyc();
    chk({tag, "_stat_frozen"}, stat_cycles, run_cnt);
    chk({tag, "_done_held"}, bus.done, 1);
`endif
  endtask

  initial begin
    int t;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.output_addr = '0;
    bus.core_done = '0;
    bus.core_hash = '0;
    hold = 1'b0;
    sync_mode = 1'b0;
    fixed_lat = 1'b1;
    bursts = 0;
    cyc_no = 0;
    last_wr_cyc = 0;
    base = '0;
    key = '0;
    model_clear();
    repeat (2) cyc();
    chk_zero("rst0");
    reset = 1'b0;
    cyc();

    // reference job: 10-cycle cores, hash = nonce ^ A5A50000, base 0x0100
    new_job(16'h0100, 32'hA5A5_0000);
    finish_job("job1");

    // completion from an idle core must not produce a write
    t = wr_cnt;
    bus.core_done[2] = 1'b1;
    bus.core_hash[2] = 32'hDEAD_BEEF;
    repeat (3) begin
      cyc();
      chk("idle_done_we", bus.mem_we, 0);
    end
    chk("idle_done_cnt", wr_cnt, t);

    // start during RUN is ignored; random latencies reorder completions
    fixed_lat = 1'b0;
    new_job(AW'($urandom), $urandom);
    repeat (5) cyc();
    bus.start = 1'b1;
    bus.output_addr = AW'($urandom);
    cyc();
    bus.start = 1'b0;
    finish_job("run_start");

    // start in DONE restarts at nonce 0 (checked on first core_start)
    repeat (2) cyc();
    chk("done_hold", bus.done, 1);
    new_job(AW'($urandom), $urandom);
    finish_job("restart");

    // reset while two results are pending
    hold = 1'b1;
    fixed_lat = 1'b1;
    new_job(16'h0200, $urandom);
    t = 0;
    while (!all_rdy() && t < 100) begin
      cyc();
      t++;
    end
    chk("hold_ready", 64'(all_rdy()), 1);
    for (int i = 0; i < 3; i++) pulse(i);
    cyc();
    chk("pre_rst_we", bus.mem_we, 1);
    reset = 1'b1;
    cyc();
    chk_zero("rst_mid");
    reset = 1'b0;
    hold = 1'b0;
    model_clear();
    repeat (3) begin
      cyc();
      chk("no_stale_start", bus.core_start, 0);
    end

    // simultaneous completions from all cores: 4-cycle bursts in core order
    sync_mode = 1'b1;
    new_job(16'h0100, 32'hA5A5_0000);
    finish_job("burst");
    chk("burst_count", bursts, NN / NC);
    sync_mode = 1'b0;

    // random jobs, first one wrapping the address space
    fixed_lat = 1'b0;
    for (int j = 0; j < 4; j++) begin
      new_job((j == 0) ? 16'hFFF8 : AW'($urandom), $urandom);
      finish_job("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
